// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control and memory-handshake bundle between the sequencer
// and the rest of the 16-bit load/store CPU (IR, register file/ALU, memory).
interface cpu_sequencer_if;
  logic        start;
  logic [15:0] instruction;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_load;
  logic        pc_inc;
  logic [3:0]  alu_control;
  logic        reg_write;
  logic        wb_sel;
  logic        halted;
  logic        retired;
  logic        mem_err;

  // Environment side: drives control inputs, observes strobes.
  modport master (
    output start, instruction, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_load, pc_inc, alu_control,
           reg_write, wb_sel, halted, retired, mem_err
  );

  // Sequencer side.
  modport slave (
    input  start, instruction, mem_ready,
    output mem_req, mem_we, addr_sel, ir_load, pc_inc, alu_control,
           reg_write, wb_sel, halted, retired, mem_err
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer.
// Optional feature macro: SEQ_MEM_TIMEOUT_EN -- aborts an instruction whose
// memory request stays unanswered for MEM_TIMEOUT consecutive cycles.
// Without it the sequencer waits indefinitely and mem_err is tied low.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STORE = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // ADD/SUB/AND/OR occupy opcodes 0000..0011.
  function automatic logic is_alu(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] op_q_r;
  logic       halted_r;
  logic       retired_r;
  logic       retire_s;
  logic       halt_set_s;
  logic       timeout_s;

  logic       mem_req_s;
  logic       mem_we_s;
  logic       addr_sel_s;
  logic       ir_load_s;
  logic       alu_active_s;
  logic [3:0] alu_control_s;
  logic       reg_write_s;
  logic       wb_sel_s;

  // State register, opcode capture, halted flag and registered retire pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      op_q_r    <= 4'b0000;
      halted_r  <= 1'b0;
      retired_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      retired_r <= retire_s;
      if (state_r == S_DECODE) begin
        op_q_r <= bus.instruction[15:12];
      end
      if (halt_set_s) begin
        halted_r <= 1'b1;
      end else if ((state_r == S_IDLE) && bus.start) begin
        halted_r <= 1'b0;
      end
    end
  end

  // Next-state decode; decisions after DECODE look only at the captured opcode.
  always_comb begin
    state_next_s = state_r;
    retire_s     = 1'b0;
    halt_set_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_next_s = S_FETCH;
        else           state_next_s = S_IDLE;
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_next_s = S_DECODE;
        end else if (timeout_s) begin
          state_next_s = S_IDLE;
          halt_set_s   = 1'b1;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (bus.instruction[15:12] == OP_HALT) begin
          state_next_s = S_IDLE;
          halt_set_s   = 1'b1;
          retire_s     = 1'b1;
        end else begin
          state_next_s = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_alu(op_q_r)) begin
          state_next_s = S_WRITEBACK;
        end else if ((op_q_r == OP_LOAD) || (op_q_r == OP_STORE)) begin
          state_next_s = S_MEM;
        end else begin
          state_next_s = S_FETCH;
          retire_s     = 1'b1;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (op_q_r == OP_LOAD) begin
            state_next_s = S_WRITEBACK;
          end else begin
            state_next_s = S_FETCH;
            retire_s     = 1'b1;
          end
        end else if (timeout_s) begin
          state_next_s = S_IDLE;
          halt_set_s   = 1'b1;
        end else begin
          state_next_s = S_MEM;
        end
      end
      S_WRITEBACK: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Datapath strobes: Moore decodes of state/op_q, except the Mealy fetch strobe.
  always_comb begin
    mem_req_s     = (state_r == S_FETCH) || (state_r == S_MEM);
    addr_sel_s    = (state_r == S_MEM);
    mem_we_s      = (state_r == S_MEM) && (op_q_r == OP_STORE);
    ir_load_s     = (state_r == S_FETCH) && bus.mem_ready;
    alu_active_s  = (state_r == S_EXECUTE) || (state_r == S_MEM);
    reg_write_s   = (state_r == S_WRITEBACK);
    wb_sel_s      = (state_r == S_WRITEBACK) && (op_q_r == OP_LOAD);
    if (alu_active_s && is_alu(op_q_r)) begin
      alu_control_s = op_q_r;
    end else begin
      alu_control_s = 4'b0000;
    end
  end

  assign bus.mem_req     = mem_req_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.addr_sel    = addr_sel_s;
  assign bus.ir_load     = ir_load_s;
  assign bus.pc_inc      = ir_load_s;
  assign bus.alu_control = alu_control_s;
  assign bus.reg_write   = reg_write_s;
  assign bus.wb_sel      = wb_sel_s;
  assign bus.halted      = halted_r;
  assign bus.retired     = retired_r;

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_r;
  logic       mem_err_r;

  // mem_ready on the limit cycle wins because the abort requires it low.
  assign timeout_s = ((state_r == S_FETCH) || (state_r == S_MEM)) && !bus.mem_ready &&
                     (wait_cnt_r == 8'(MEM_TIMEOUT - 1));

  // Consecutive unanswered request cycles; restarts on mem_ready or state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 8'd0;
    end else if (bus.mem_ready || (state_next_s != state_r)) begin
      wait_cnt_r <= 8'd0;
    end else if ((state_r == S_FETCH) || (state_r == S_MEM)) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= 8'd0;
    end
  end

  // One-cycle error pulse coincident with the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) mem_err_r <= 1'b0;
    else     mem_err_r <= timeout_s;
  end

  assign bus.mem_err = mem_err_r;
`else
  assign timeout_s   = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  // Operand/immediate bits of the IR are consumed by the datapath, not here.
  logic unused_s;
  assign unused_s = ^{1'b0, bus.instruction[11:0], 8'(MEM_TIMEOUT)};

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven instruction stream with a per-cycle
// expected-output scoreboard, plus hand-written reset and timeout sequences.
module tb_cpu_sequencer;

  logic clk;
  logic rst;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_load;
    logic       pc_inc;
    logic [3:0] alu_control;
    logic       reg_write;
    logic       wb_sel;
    logic       halted;
    logic       retired;
    logic       mem_err;
  } out_t;

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_NOP, K_HALT} kind_t;

  typedef struct {
    logic [15:0] ir;
    kind_t       kind;
    logic [3:0]  exp_alu;
    logic        exp_we;
    int          fw;   // fetch wait cycles
    int          mw;   // memory wait cycles
  } vec_t;

  vec_t tbl [10];
  out_t exp_q [$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc_no = 0;
  logic halted_m  = 1'b0;
  logic ret_pend  = 1'b0;

  function automatic out_t base();
    out_t e;
    e = '0;
    e.halted = halted_m;
    return e;
  endfunction

  // One clock cycle: drive inputs, queue expectation, compare at negedge.
  task automatic cyc(input string name, input logic st, input logic rdy,
                     input logic [15:0] ir, input logic rs, input out_t e);
    out_t got;
    out_t want;
    rst             = rs;
    bus.start       = st;
    bus.mem_ready   = rdy;
    bus.instruction = ir;
    exp_q.push_back(e);
    @(negedge clk);
    got = '{bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_load, bus.pc_inc,
            bus.alu_control, bus.reg_write, bus.wb_sel, bus.halted,
            bus.retired, bus.mem_err};
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got req/we/as/irl/pci/alu/rw/wbs/hlt/ret/err=%b expected %b",
               name, cyc_no, got, want);
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  // Run one instruction from its first FETCH cycle to its final state.
  task automatic run_vec(input vec_t v);
    out_t e;
    for (int i = 0; i <= v.fw; i++) begin
      e = base();
      e.mem_req = 1'b1;
      e.ir_load = (i == v.fw);
      e.pc_inc  = (i == v.fw);
      if (i == 0) e.retired = ret_pend;
      cyc("fetch", 1'b1, (i == v.fw), 16'($urandom), 1'b0, e);
      ret_pend = 1'b0;
    end
    e = base();
    cyc("decode", 1'b1, 1'b1, v.ir, 1'b0, e);
    if (v.kind == K_HALT) begin
      ret_pend = 1'b1;
      halted_m = 1'b1;
      return;
    end
    e = base();
    e.alu_control = v.exp_alu;
    cyc("execute", 1'b1, 1'b1, 16'($urandom), 1'b0, e);
    if ((v.kind == K_LOAD) || (v.kind == K_STORE)) begin
      for (int j = 0; j <= v.mw; j++) begin
        e = base();
        e.mem_req     = 1'b1;
        e.addr_sel    = 1'b1;
        e.mem_we      = v.exp_we;
        e.alu_control = v.exp_alu;
        cyc("mem", 1'b1, (j == v.mw), 16'($urandom), 1'b0, e);
      end
    end
    if ((v.kind == K_ALU) || (v.kind == K_LOAD)) begin
      e = base();
      e.reg_write = 1'b1;
      e.wb_sel    = (v.kind == K_LOAD);
      cyc("writeback", 1'b1, 1'b1, 16'($urandom), 1'b0, e);
    end
    ret_pend = 1'b1;
  endtask

  initial begin
    out_t e;
    vec_t v;

    tbl[0] = '{16'h0123, K_ALU,   4'b0000, 1'b0, 0, 0};
    tbl[1] = '{16'h4567, K_LOAD,  4'b0000, 1'b0, 0, 3};
    tbl[2] = '{16'h5000, K_STORE, 4'b0000, 1'b1, 1, 0};
    tbl[3] = '{16'h2000, K_ALU,   4'b0010, 1'b0, 0, 0};
    tbl[4] = '{16'h1ABC, K_ALU,   4'b0001, 1'b0, 2, 0};
    tbl[5] = '{16'h3001, K_ALU,   4'b0011, 1'b0, 0, 0};
    tbl[6] = '{16'h7000, K_NOP,   4'b0000, 1'b0, 0, 0};
    tbl[7] = '{16'h5123, K_STORE, 4'b0000, 1'b1, 0, 2};
    tbl[8] = '{16'hE0FF, K_NOP,   4'b0000, 1'b0, 1, 0};
    tbl[9] = '{16'hF000, K_HALT,  4'b0000, 1'b0, 0, 0};

    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.instruction = 16'h0000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Reset state, then an idle cycle, then start.
    cyc("reset_state", 1'b0, 1'b0, 16'h0000, 1'b1, base());
    cyc("idle", 1'b0, 1'b1, 16'h0000, 1'b0, base());
    cyc("start", 1'b1, 1'b0, 16'h0000, 1'b0, base());
    halted_m = 1'b0;

    for (int k = 0; k < 10; k++) begin
      run_vec(tbl[k]);
    end

    // After HALT: IDLE with retired pulse, halted held until start.
    e = base();
    e.retired = ret_pend;
    cyc("halt_idle", 1'b0, 1'b1, 16'h0000, 1'b0, e);
    ret_pend = 1'b0;
    cyc("halt_hold", 1'b0, 1'b1, 16'h0000, 1'b0, base());
    cyc("restart", 1'b1, 1'b0, 16'h0000, 1'b0, base());
    halted_m = 1'b0;
    v = tbl[0];
    run_vec(v);

    // STORE interrupted by reset in its second MEM cycle.
    e = base();
    e.mem_req = 1'b1; e.ir_load = 1'b1; e.pc_inc = 1'b1; e.retired = ret_pend;
    cyc("rst_fetch", 1'b0, 1'b1, 16'h0000, 1'b0, e);
    ret_pend = 1'b0;
    cyc("rst_decode", 1'b0, 1'b0, 16'h5000, 1'b0, base());
    cyc("rst_execute", 1'b0, 1'b0, 16'h0000, 1'b0, base());
    e = base();
    e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
    cyc("rst_mem1", 1'b0, 1'b0, 16'h0000, 1'b0, e);
    cyc("rst_mem2", 1'b0, 1'b0, 16'h0000, 1'b1, e);
    cyc("rst_after", 1'b0, 1'b1, 16'h0000, 1'b0, base());
    cyc("rst_idle", 1'b0, 1'b1, 16'h0000, 1'b0, base());

    // Unanswered fetch.
    cyc("to_start", 1'b1, 1'b0, 16'h0000, 1'b0, base());
`ifdef SEQ_MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      e = base();
      e.mem_req = 1'b1;
      cyc("to_fetch", 1'b0, 1'b0, 16'h0000, 1'b0, e);
    end
    halted_m = 1'b1;
    e = base();
    e.mem_err = 1'b1;
    cyc("to_err", 1'b0, 1'b0, 16'h0000, 1'b0, e);
    cyc("to_idle", 1'b0, 1'b1, 16'h0000, 1'b0, base());
`else
    for (int i = 0; i < 100; i++) begin
      e = base();
      e.mem_req = 1'b1;
      cyc("wait_fetch", 1'b1, 1'b0, 16'h0000, 1'b0, e);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
